// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the 4-bit MAC: buffers up to DEPTH operand pairs, streams them
// into the MAC on consecutive cycles and returns the MAC result with a one-cycle pulse.
module mac_seq_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15,
  parameter int DATA_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        cfg_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_a,
  input  logic [DATA_W-1:0] ld_b,
  output logic              ld_ready,
  output logic [DATA_W-1:0] mac_in1,
  output logic [DATA_W-1:0] mac_in2,
  output logic              mac_in_valid,
  input  logic [9:0]        mac_out,
  input  logic              mac_out_valid,
  output logic [9:0]        res,
  output logic              res_valid,
  output logic              busy,
  output logic              err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [2:0]    DEPTH_L  = 3'(DEPTH);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          len_q, len_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_d;
  logic [9:0]          res_d;
  logic [2*DATA_W-1:0] feed_d;
  logic                wr_en;
  logic [AW-1:0]       rd_sel;
  logic [2*DATA_W-1:0] pair_mem [DEPTH];

  assign rd_sel = AW'(idx_q + 3'd1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err;
    res_d   = res;
    feed_d  = '0;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((cfg_len != 3'd0) && (cfg_len <= DEPTH_L)) begin
            len_d   = cfg_len;
            idx_d   = 3'd0;
            err_d   = 1'b0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (ld_valid && ld_ready) begin
          wr_en = 1'b1;
          if (idx_q == len_q - 3'd1) begin
            idx_d   = 3'd0;
            state_d = S_FEED;
            // A single-pair job is being written this very edge, so bypass the buffer
            feed_d  = (idx_q == 3'd0) ? {ld_a, ld_b} : pair_mem[0];
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_FEED: begin
        if (idx_q == len_q - 3'd1) begin
          idx_d   = 3'd0;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          idx_d  = idx_q + 3'd1;
          feed_d = pair_mem[rd_sel];
        end
      end
      S_WAIT: begin
        if (mac_out_valid) begin
          res_d   = mac_out;
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered control and outputs: each output is decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      err          <= 1'b0;
      res          <= '0;
      ld_ready     <= 1'b0;
      mac_in_valid <= 1'b0;
      mac_in1      <= '0;
      mac_in2      <= '0;
      res_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      err          <= err_d;
      res          <= res_d;
      ld_ready     <= (state_d == S_LOAD);
      mac_in_valid <= (state_d == S_FEED);
      mac_in1      <= feed_d[2*DATA_W-1:DATA_W];
      mac_in2      <= feed_d[DATA_W-1:0];
      res_valid    <= (state_d == S_DONE);
      busy         <= (state_d != S_IDLE);
    end
  end

  // Operand buffer holds no reset; its contents are only read after being written
  always_ff @(posedge clk) begin
    if (wr_en) pair_mem[AW'(idx_q)] <= {ld_a, ld_b};
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural MAC that answers one cycle
// after its input stream ends.
module tb_mac_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] cfg_len = 3'd0;
  logic       ld_valid = 1'b0;
  logic [3:0] ld_a = 4'd0;
  logic [3:0] ld_b = 4'd0;
  logic       ld_ready;
  logic [3:0] mac_in1, mac_in2;
  logic       mac_in_valid;
  logic [9:0] mac_out;
  logic       mac_out_valid;
  logic [9:0] res;
  logic       res_valid, busy, err;

  int checks = 0;
  int errors = 0;

  mac_seq_ctrl #(.DEPTH(4), .TIMEOUT(15), .DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .ld_valid(ld_valid), .ld_a(ld_a), .ld_b(ld_b), .ld_ready(ld_ready),
    .mac_in1(mac_in1), .mac_in2(mac_in2), .mac_in_valid(mac_in_valid),
    .mac_out(mac_out), .mac_out_valid(mac_out_valid),
    .res(res), .res_valid(res_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // MAC model: accumulate while in_valid, report one cycle after the stream ends
  logic       mac_en = 1'b1;
  logic [9:0] acc;
  logic       prev_v;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; prev_v <= 1'b0; mac_out_valid <= 1'b0; mac_out <= '0;
    end else begin
      prev_v <= mac_in_valid;
      mac_out_valid <= 1'b0;
      if (mac_in_valid) acc <= acc + 10'(mac_in1) * 10'(mac_in2);
      else if (prev_v) begin
        acc <= '0;
        if (mac_en) begin mac_out_valid <= 1'b1; mac_out <= acc; end
      end
    end
  end

  // Observation log of what the MAC port and load port saw
  int cyc = 0, nseen = 0, nacc = 0, nstale = 0, acc_last = 0, first_v = 0, last_v = 0;
  logic [3:0] sa [8];
  logic [3:0] sb [8];
  always @(posedge clk) begin
    if (rst_n) begin
      if (mac_in_valid) begin
        if (nseen < 8) begin sa[nseen] = mac_in1; sb[nseen] = mac_in2; end
        if (nseen == 0) first_v = cyc;
        last_v = cyc;
        nseen++;
      end else if (mac_in1 != 4'd0 || mac_in2 != 4'd0) nstale++;
      if (ld_valid && ld_ready) begin nacc++; acc_last = cyc; end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input logic [2:0] len);
    start = 1'b1; cfg_len = len;
    step();
    start = 1'b0;
  endtask

  task automatic load_pair(input logic [3:0] a, input logic [3:0] b, input int gap);
    logic ok;
    repeat (gap) step();
    ld_valid = 1'b1; ld_a = a; ld_b = b; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (ld_ready) ok = 1'b1;
      step();
    end
    ld_valid = 1'b0;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL load_accept: ld_ready=%b never seen, required 1", ok); end
  endtask

  task automatic wait_res(input int max, output int pulses, output logic [9:0] r);
    pulses = 0; r = '0;
    for (int i = 0; i < max; i++) begin
      step();
      if (res_valid) begin pulses++; r = res; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({ld_ready, mac_in_valid, res_valid, busy, err} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b, required 00000", {ld_ready, mac_in_valid, res_valid, busy, err}); end
    checks++; if ({mac_in1, mac_in2, res} !== 18'd0) begin errors++; $display("FAIL reset_data: in1=%0d in2=%0d res=%0d, required 0", mac_in1, mac_in2, res); end
    rst_n = 1'b1;
    step();
    checks++; if ({busy, ld_ready, err} !== 3'b0) begin errors++; $display("FAIL reset_idle: busy/ready/err=%b, required 000", {busy, ld_ready, err}); end
  endtask

  task automatic test_basic();
    int p; logic [9:0] r;
    nseen = 0;
    start_job(3'd2);
    checks++; if ({busy, ld_ready} !== 2'b11) begin errors++; $display("FAIL basic_start: busy/ready=%b, required 11", {busy, ld_ready}); end
    load_pair(4'd1, 4'd2, 0);
    load_pair(4'd3, 4'd4, 0);
    checks++; if (ld_ready !== 1'b0 || mac_in_valid !== 1'b1) begin errors++; $display("FAIL basic_feed_entry: ready=%b in_valid=%b, required 0 1", ld_ready, mac_in_valid); end
    wait_res(30, p, r);
    checks++; if (r !== 10'd14) begin errors++; $display("FAIL basic_res: got %0d, required 14", r); end
    checks++; if (p !== 1) begin errors++; $display("FAIL basic_pulse: got %0d pulses, required 1", p); end
    checks++; if ({err, busy} !== 2'b00) begin errors++; $display("FAIL basic_end: err/busy=%b, required 00", {err, busy}); end
    checks++; if (nseen !== 2 || last_v - first_v !== 1) begin errors++; $display("FAIL basic_stream: %0d beats span %0d, required 2 span 1", nseen, last_v - first_v); end
    checks++; if ({sa[0], sb[0], sa[1], sb[1]} !== {4'd1, 4'd2, 4'd3, 4'd4}) begin errors++; $display("FAIL basic_order: got %0d,%0d %0d,%0d, required 1,2 3,4", sa[0], sb[0], sa[1], sb[1]); end
    checks++; if (res !== 10'd14) begin errors++; $display("FAIL basic_hold: res=%0d, required 14", res); end
  endtask

  task automatic test_full_depth();
    int p; logic [9:0] r;
    nseen = 0;
    start_job(3'd4);
    for (int i = 0; i < 4; i++) load_pair(4'd15, 4'd15, 0);
    wait_res(30, p, r);
    checks++; if (r !== 10'd900 || p !== 1) begin errors++; $display("FAIL full_res: got %0d (%0d pulses), required 900 (1)", r, p); end
    checks++; if (nseen !== 4 || last_v - first_v !== 3) begin errors++; $display("FAIL full_valid_len: %0d beats span %0d, required 4 span 3", nseen, last_v - first_v); end
  endtask

  task automatic test_backpressure();
    int p; logic [9:0] r;
    nseen = 0; nacc = 0;
    start_job(3'd3);
    load_pair(4'd5, 4'd6, 2);
    load_pair(4'd7, 4'd8, 2);
    load_pair(4'd9, 4'd10, 2);
    ld_valid = 1'b1; ld_a = 4'd1; ld_b = 4'd1;
    repeat (4) step();
    ld_valid = 1'b0;
    wait_res(30, p, r);
    checks++; if (nacc !== 3) begin errors++; $display("FAIL bp_accepts: got %0d, required 3", nacc); end
    checks++; if (first_v !== acc_last + 1) begin errors++; $display("FAIL bp_feed_start: first beat %0d, required %0d", first_v, acc_last + 1); end
    checks++; if ({sa[0], sb[0], sa[1], sb[1], sa[2], sb[2]} !== {4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10}) begin errors++; $display("FAIL bp_order: got %0d,%0d %0d,%0d %0d,%0d, required 5,6 7,8 9,10", sa[0], sb[0], sa[1], sb[1], sa[2], sb[2]); end
    checks++; if (r !== 10'd176 || p !== 1) begin errors++; $display("FAIL bp_res: got %0d (%0d pulses), required 176 (1)", r, p); end
  endtask

  task automatic test_timeout();
    int p; logic [9:0] r; int pulses;
    mac_en = 1'b0; pulses = 0;
    start_job(3'd1);
    load_pair(4'd2, 4'd3, 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (res_valid) pulses++;
      if (i == 15) begin
        checks++; if ({err, busy} !== 2'b01) begin errors++; $display("FAIL tmo_early: err/busy=%b, required 01", {err, busy}); end
      end
    end
    checks++; if ({err, busy} !== 2'b10) begin errors++; $display("FAIL tmo_fire: err/busy=%b, required 10", {err, busy}); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL tmo_no_pulse: got %0d pulses, required 0", pulses); end
    mac_en = 1'b1;
    start_job(3'd1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_clear: err=%b, required 0", err); end
    load_pair(4'd4, 4'd5, 0);
    wait_res(30, p, r);
    checks++; if (r !== 10'd20 || p !== 1) begin errors++; $display("FAIL tmo_recover: got %0d (%0d pulses), required 20 (1)", r, p); end
  endtask

  task automatic test_illegal();
    logic got; logic [9:0] r;
    start_job(3'd0);
    checks++; if ({err, busy, ld_ready} !== 3'b100) begin errors++; $display("FAIL len0: err/busy/ready=%b, required 100", {err, busy, ld_ready}); end
    start_job(3'd5);
    checks++; if ({err, busy, ld_ready} !== 3'b100) begin errors++; $display("FAIL len5: err/busy/ready=%b, required 100", {err, busy, ld_ready}); end
    nseen = 0;
    start_job(3'd2);
    load_pair(4'd1, 4'd1, 0);
    load_pair(4'd2, 4'd2, 0);
    start = 1'b1; cfg_len = 3'd3;
    step();
    start = 1'b0;
    got = 1'b0; r = '0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (res_valid) begin
        got = 1'b1; r = res;
        start = 1'b1; cfg_len = 3'd2;
        step();
        start = 1'b0;
      end
    end
    checks++; if (got !== 1'b1 || r !== 10'd5) begin errors++; $display("FAIL feed_start_ignored: res=%0d seen=%b, required 5 1", r, got); end
    checks++; if (nseen !== 2) begin errors++; $display("FAIL feed_start_beats: got %0d, required 2", nseen); end
    checks++; if ({busy, ld_ready} !== 2'b00) begin errors++; $display("FAIL done_start_ignored: busy/ready=%b, required 00", {busy, ld_ready}); end
  endtask

  task automatic test_reset_mid_feed();
    int p; logic [9:0] r;
    start_job(3'd4);
    load_pair(4'd1, 4'd1, 0);
    load_pair(4'd2, 4'd2, 0);
    load_pair(4'd3, 4'd3, 0);
    load_pair(4'd4, 4'd4, 0);
    step();
    checks++; if (mac_in_valid !== 1'b1 || mac_in1 !== 4'd2) begin errors++; $display("FAIL rst_pre: in_valid=%b in1=%0d, required 1 2", mac_in_valid, mac_in1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mac_in_valid, busy, res_valid, ld_ready} !== 4'b0) begin errors++; $display("FAIL rst_async: valid/busy/resv/ready=%b, required 0000", {mac_in_valid, busy, res_valid, ld_ready}); end
    checks++; if ({mac_in1, mac_in2, res} !== 18'd0) begin errors++; $display("FAIL rst_async_data: in1=%0d in2=%0d res=%0d, required 0", mac_in1, mac_in2, res); end
    step();
    rst_n = 1'b1;
    step();
    nseen = 0;
    start_job(3'd2);
    load_pair(4'd6, 4'd7, 0);
    load_pair(4'd1, 4'd1, 0);
    wait_res(30, p, r);
    checks++; if (r !== 10'd43 || p !== 1 || nseen !== 2) begin errors++; $display("FAIL rst_recover: res=%0d pulses=%0d beats=%0d, required 43 1 2", r, p, nseen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_depth();
    test_backpressure();
    test_timeout();
    test_illegal();
    test_reset_mid_feed();
    checks++; if (nstale !== 0) begin errors++; $display("FAIL stale_operands: %0d idle cycles with nonzero operands, required 0", nstale); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer that owns the 4-bit MAC datapath (`MAC_v4`: `in1_IFM`, `in2_IFM`, `in_valid` in; 10-bit `out`, `out_valid` back). It accepts a dot-product job of 1..4 operand pairs through a valid/ready load port and buffers the pairs. It then streams them into the MAC on consecutive cycles, waits (bounded) for the MAC result and returns it with a one-cycle result pulse. It sits between the IFM/weight fetch logic and the MAC instance.

## Interface
- `DEPTH`, 4: maximum operands per job. 4·15·15 = 900 fits the MAC's 10-bit output.
- `TIMEOUT`, 15: maximum cycles spent in WAIT before the job is declared failed.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request, sampled only in IDLE.
- `cfg_len` in 3: number of operand pairs, sampled with `start`.
- `ld_valid` in 1: load pair valid.
- `ld_a` in 4: IFM operand.
- `ld_b` in 4: weight operand.
- `ld_ready` out 1: controller accepts a pair.
- `mac_in1` out 4: to MAC `in1_IFM`.
- `mac_in2` out 4: to MAC `in2_IFM`.
- `mac_in_valid` out 1: to MAC `in_valid`.
- `mac_out` in 10: from MAC `out`.
- `mac_out_valid` in 1: from MAC `out_valid`.
- `res` out 10: captured result, held until the next capture.
- `res_valid` out 1: one-cycle pulse, `res` valid.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: sticky job error, cleared by the next accepted `start`.

## Operation
- States: IDLE, LOAD, FEED, WAIT, DONE. Every output is registered.
- **IDLE**
  - `start`=1 with 1 ≤ `cfg_len` ≤ DEPTH: latch len, clear idx and `err`, go to LOAD.
  - `start`=1 with `cfg_len`=0 or `cfg_len` > DEPTH: set `err`, stay in IDLE.
- **LOAD**
  - `ld_ready`=1.
  - On each `ld_valid && ld_ready`: write buffer[idx] = {`ld_a`,`ld_b`} and increment idx.
  - When the accepted pair is the len-th: clear idx, go to FEED.
  - `ld_valid` gaps are legal; the controller waits indefinitely.
- **FEED**
  - Drive `mac_in_valid`=1 with buffer[idx] on `mac_in1`/`mac_in2` for exactly len consecutive cycles, in load order.
  - After the last pair, go to WAIT and clear the timeout counter.
- **WAIT**
  - `mac_out_valid`=1: capture `mac_out` into `res`, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: set `err`, go to IDLE without a `res_valid` pulse.
- **DONE**
  - `res_valid`=1 for one cycle, then go to IDLE.
- Whenever `mac_in_valid`=0, `mac_in1`/`mac_in2` are driven to 0, so the MAC never sees stale operands.
- `mac_out_valid` is ignored outside WAIT.
- `start` is ignored outside IDLE, including in DONE.
- `ld_valid` outside LOAD is ignored and not acknowledged.
- The controller does no arithmetic. `res` is the MAC value bit-exact.

## Timing
- Reset values:
  - state IDLE.
  - `ld_ready`, `mac_in_valid`, `res_valid`, `busy`, `err` = 0.
  - `mac_in1`, `mac_in2` = 0; `res` = 0.
  - Buffer contents are don't-care.
- Reset mid-job: asynchronous return to IDLE, all outputs at reset values in the same instant. `mac_in_valid` drops immediately, with no partial FEED continuation.
- `start` accepted at edge T: `busy`=1 and `ld_ready`=1 from T+1.
- Last pair accepted at edge L: `ld_ready`=0 from L+1; `mac_in_valid` high for cycles L+1 .. L+len.
- WAIT begins at cycle L+len+1.
- `mac_out_valid` sampled at edge W: `res` updates at W+1, `res_valid` high for cycle W+1, `busy`=0 from W+2.
- Best case, len pairs loaded back-to-back with MAC latency 1: start to `res_valid` is len + len + 3 cycles.
- Timeout: `err`=1 and `busy`=0 at the edge where the counter hits TIMEOUT, i.e. TIMEOUT cycles after WAIT entry.

## Test plan
- **Basic job:** reset, `start` with len=2, load (1,2),(3,4).
  - MAC sees (1,2),(3,4) on consecutive cycles; the MAC model returns 14.
  - `res`=14, `res_valid` one cycle, `err`=0.
- **Full depth:** len=4, all pairs (15,15), MAC returns 900.
  - `res`=900, `mac_in_valid` high exactly 4 cycles.
- **Load backpressure:** len=3 with `ld_valid` gaps of 2 cycles.
  - Exactly 3 pairs accepted.
  - FEED starts the cycle after the 3rd acceptance; MAC operands are in order.
- **Timeout:** len=1 and the MAC model never asserts `mac_out_valid`.
  - `err`=1 after TIMEOUT=15 WAIT cycles, no `res_valid`, return to IDLE.
  - The next `start` clears `err`.
- **Illegal/ignored requests:**
  - `start` with len=0: `err`=1, `busy` stays 0.
  - `start` pulsed during FEED: ignored, and the job completes normally.
- **Reset mid-FEED:** assert `rst_n`=0 during the 2nd of 4 FEED cycles.
  - `mac_in_valid`, `busy`, `res_valid` = 0 immediately.
  - After release, a new len=2 job completes correctly.
